// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter: valid/ready word load, MSB-first serial output gated by out_en.
// Optional even-parity trailer bit when the PISO_PARITY_EN macro is defined.
module piso_serializer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             out_en,
  output logic             ser_out,
  output logic             ser_frame,
  output logic             ser_last
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_sreg;
  logic [CNT_W-1:0] r_cnt;
  logic             w_accept;
  logic             w_cnt_zero;
`ifdef PISO_PARITY_EN
  logic             r_par;
`endif

  assign w_cnt_zero = (r_cnt == '0);

`ifdef PISO_PARITY_EN
  assign load_ready = (r_state == IDLE) | (r_state == PAR);
`else
  // The last data cycle doubles as the load slot so frames run back to back.
  assign load_ready = (r_state == IDLE) | ((r_state == SHIFT) & w_cnt_zero);
`endif

  assign w_accept = load_valid & load_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_sreg  <= '0;
      r_cnt   <= '0;
`ifdef PISO_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      case (r_state)
        SHIFT: begin
          r_sreg <= r_sreg << 1;
          if (w_cnt_zero) begin
`ifdef PISO_PARITY_EN
            r_state <= PAR;
`else
            r_state <= IDLE;
`endif
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
`ifdef PISO_PARITY_EN
        PAR: r_state <= IDLE;
`endif
        default: ;
      endcase
      // A new word overrides whatever the frame logic above decided.
      if (w_accept) begin
        r_sreg  <= load_data;
        r_cnt   <= CNT_W'(WIDTH - 1);
        r_state <= SHIFT;
`ifdef PISO_PARITY_EN
        r_par   <= ^load_data;
`endif
      end
    end
  end

  always_comb begin
    ser_out   = 1'b0;
    ser_frame = 1'b0;
    ser_last  = 1'b0;
    case (r_state)
      SHIFT: begin
        ser_frame = 1'b1;
        ser_out   = r_sreg[WIDTH-1] & out_en;
`ifndef PISO_PARITY_EN
        ser_last  = w_cnt_zero;
`endif
      end
`ifdef PISO_PARITY_EN
      PAR: begin
        ser_frame = 1'b1;
        ser_out   = r_par & out_en;
        ser_last  = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: queue-based frame model checked every cycle, plus directed literal sequences.
module tb_piso_serializer;
  localparam int WIDTH = 4;
`ifdef PISO_PARITY_EN
  localparam int FL = WIDTH + 1;
  localparam logic [31:0] E2_SO = 32'b10111;
  localparam logic [31:0] E2_LA = 32'b00001;
  localparam logic [31:0] E3_SO = 32'b1011101100;
  localparam logic [31:0] E3_LA = 32'b0000100001;
  localparam logic [31:0] E4_OE = 32'b11011;
  localparam logic [31:0] E4_SO = 32'b11010;
  localparam logic [31:0] E5_SO = 32'b00011;
`else
  localparam int FL = WIDTH;
  localparam logic [31:0] E2_SO = 32'b1011;
  localparam logic [31:0] E2_LA = 32'b0001;
  localparam logic [31:0] E3_SO = 32'b10110110;
  localparam logic [31:0] E3_LA = 32'b00010001;
  localparam logic [31:0] E4_OE = 32'b1101;
  localparam logic [31:0] E4_SO = 32'b1101;
  localparam logic [31:0] E5_SO = 32'b0001;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [WIDTH-1:0] load_data = '0;
  logic             load_valid = 1'b0;
  logic             load_ready;
  logic             out_en = 1'b1;
  logic             ser_out;
  logic             ser_frame;
  logic             ser_last;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;
  bit mq[$];

  piso_serializer #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .load_data(load_data), .load_valid(load_valid),
    .load_ready(load_ready), .out_en(out_en), .ser_out(ser_out),
    .ser_frame(ser_frame), .ser_last(ser_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b, expected %b", nm, $time, act, exp);
    end
  endtask

  // Model: the bits still to be sent in the current frame, head = bit on the line now.
  always @(posedge clk) begin
    bit rdy;
    if (rst) begin
      mq.delete();
    end else begin
      rdy = (mq.size() <= 1);
      if (mq.size() > 0) void'(mq.pop_front());
      if (load_valid && rdy) begin
        for (int i = WIDTH - 1; i >= 0; i--) mq.push_back(load_data[i]);
`ifdef PISO_PARITY_EN
        mq.push_back(^load_data);
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ser_frame", {31'b0, ser_frame}, {31'b0, mq.size() > 0});
      chk("ser_out", {31'b0, ser_out}, {31'b0, (mq.size() > 0) ? (mq[0] & out_en) : 1'b0});
      chk("ser_last", {31'b0, ser_last}, {31'b0, mq.size() == 1});
      chk("load_ready", {31'b0, load_ready}, {31'b0, mq.size() <= 1});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic grab(input int n, input logic [31:0] oe_pat, input int drop_at,
                      output logic [31:0] so, output logic [31:0] fr,
                      output logic [31:0] la, output logic [31:0] rd);
    so = '0; fr = '0; la = '0; rd = '0;
    for (int i = 0; i < n; i++) begin
      out_en = oe_pat[n-1-i];
      @(negedge clk);
      so = {so[30:0], ser_out};
      fr = {fr[30:0], ser_frame};
      la = {la[30:0], ser_last};
      rd = {rd[30:0], load_ready};
      tick();
      if (i == drop_at) load_valid = 1'b0;
    end
    out_en = 1'b1;
  endtask

  task automatic send(input logic [WIDTH-1:0] d);
    load_data = d;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
  endtask

  logic [31:0] so, fr, la, rd;
  logic [31:0] ones;

  initial begin
    ones = (32'd1 << FL) - 1;

    // Reset with a valid word pending: nothing may be sent afterwards.
    rst = 1'b1; load_valid = 1'b1; load_data = 4'b1111;
    tick(); tick();
    rst = 1'b0; load_valid = 1'b0;
    chk_en = 1'b1;
    grab(3, 32'hFFFF_FFFF, -1, so, fr, la, rd);
    chk("rst_so", so, 32'b000);
    chk("rst_frame", fr, 32'b000);
    chk("rst_last", la, 32'b000);
    chk("rst_ready", rd, 32'b111);

    // Single word.
    send(4'b1011);
    chk("model_len", mq.size(), FL);
    grab(FL, 32'hFFFF_FFFF, -1, so, fr, la, rd);
    chk("t2_so", so, E2_SO);
    chk("t2_frame", fr, ones);
    chk("t2_last", la, E2_LA);
    chk("t2_ready", rd, E2_LA);

    // Back-to-back: second word held valid until accepted in the last frame cycle.
    load_data = 4'b1011; load_valid = 1'b1;
    tick();
    load_data = 4'b0110;
    grab(2 * FL, 32'hFFFF_FFFF, FL - 1, so, fr, la, rd);
    chk("t3_so", so, E3_SO);
    chk("t3_frame", fr, (32'd1 << (2 * FL)) - 1);
    chk("t3_last", la, E3_LA);
    chk("t3_ready", rd, E3_LA);

    // Output enable gating.
    send(4'b1111);
    grab(FL, 32'h0, -1, so, fr, la, rd);
    chk("t4a_so", so, 32'b0);
    chk("t4a_frame", fr, ones);
    chk("t4a_last", la, E2_LA);
    send(4'b1111);
    grab(FL, E4_OE, -1, so, fr, la, rd);
    chk("t4b_so", so, E4_SO);

    // Reset in frame cycle 2 abandons the word.
    send(4'b1100);
    @(negedge clk);
    chk("t5_bit1", {31'b0, ser_out}, 32'd1);
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("t5_bit2", {31'b0, ser_out}, 32'd1);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("t5_frame", {31'b0, ser_frame}, 32'd0);
    chk("t5_out", {31'b0, ser_out}, 32'd0);
    chk("t5_last", {31'b0, ser_last}, 32'd0);
    chk("t5_ready", {31'b0, load_ready}, 32'd1);
    tick();
    send(4'b0001);
    grab(FL, 32'hFFFF_FFFF, -1, so, fr, la, rd);
    chk("t5_reload", so, E5_SO);

    // Randomized traffic against the queue model.
    for (int c = 0; c < 3000; c++) begin
      load_valid = ($urandom_range(0, 2) != 0);
      load_data  = WIDTH'($urandom);
      out_en     = ($urandom_range(0, 3) != 0);
      rst        = ($urandom_range(0, 99) == 0);
      tick();
    end
    rst = 1'b0; load_valid = 1'b0;
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
